sar_search: RTL and testbench

Successive-approximation search engine that determines an unknown N-bit target value visible only through an external magnitude comparator. It drives the comparator's probe operand, samples the comparator's less/greater/equal flags each cycle, and resolves one bit per cycle MSB-first. It sits on the input side of a comparator instance, acting as its initiator, and reports the recovered value with a done/found handshake.

---
 rtl/sar_search_pkg.sv | 19 +
 rtl/sar_search_if.sv | 29 ++
 rtl/sar_search.sv | 118 +++++++++++
 tb/tb_sar_search.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/sar_search_pkg.sv
// rtl/sar_search_pkg.sv - shared types and helpers for the SAR search engine
// Contents: sar_state_t (2-bit FSM encoding), SAR_N_DEFAULT, onehot3().
package sar_search_pkg;

    localparam int SAR_N_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } sar_state_t;

    // True when exactly one of the three comparator flags is asserted.
    function automatic logic onehot3(input logic lt, input logic gt, input logic eq);
        return (lt ^ gt ^ eq) && !(lt && gt && eq);
    endfunction

endpackage

// File: rtl/sar_search_if.sv
// rtl/sar_search_if.sv - start/result handshake plus comparator probe/flags
// Signals: start, busy, done, found, err, result[N], probe[N], lt, gt, eq.
// master: the search engine; slave: the requester/comparator side.
interface sar_search_if
    import sar_search_pkg::*;
#(
    parameter int N = SAR_N_DEFAULT
) ();
    logic         start;
    logic         busy;
    logic         done;
    logic         found;
    logic         err;
    logic [N-1:0] result;
    logic [N-1:0] probe;
    logic         lt;
    logic         gt;
    logic         eq;

    modport master (
        input  start, lt, gt, eq,
        output busy, done, found, err, result, probe
    );

    modport slave (
        output start, lt, gt, eq,
        input  busy, done, found, err, result, probe
    );
endinterface

// File: rtl/sar_search.sv
// rtl/sar_search.sv - successive-approximation search through an external comparator
// Ports: clk, rst_n (async, active-low), bus (sar_search_if.master):
//   start in; probe out to comparator; lt/gt/eq in; busy/done/found/err/result out.
// Option: SAR_EARLY_EXIT_EN - finish as soon as the comparator reports eq during search.
module sar_search
    import sar_search_pkg::*;
#(
    parameter int N = SAR_N_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    sar_search_if.master  bus
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    sar_state_t   state, state_next;
    logic [IW-1:0] idx, idx_next;
    logic [N-1:0] probe, probe_next;
    logic [N-1:0] result, result_next;
    logic         found, found_next;
    logic         err, err_next;
    logic         flags_ok;
    logic         early_hit;

    assign flags_ok = onehot3(bus.lt, bus.gt, bus.eq);

`ifdef SAR_EARLY_EXIT_EN
    assign early_hit = bus.eq;
`else
    // eq behaves as lt: the bit is kept and the search always runs to completion.
    assign early_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= IW'(N - 1);
            probe  <= '0;
            result <= '0;
            found  <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_next;
            idx    <= idx_next;
            probe  <= probe_next;
            result <= result_next;
            found  <= found_next;
            err    <= err_next;
        end
    end

    always_comb begin
        state_next  = state;
        idx_next    = idx;
        probe_next  = probe;
        result_next = result;
        found_next  = found;
        err_next    = err;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    probe_next        = '0;
                    probe_next[N-1]   = 1'b1;
                    idx_next          = IW'(N - 1);
                    found_next        = 1'b0;
                    err_next          = 1'b0;
                    state_next        = SEARCH;
                end
            end
            SEARCH: begin
                if (!flags_ok) begin
                    err_next    = 1'b1;
                    found_next  = 1'b0;
                    result_next = probe;
                    state_next  = DONE;
                end else if (early_hit) begin
                    result_next = probe;
                    found_next  = 1'b1;
                    state_next  = DONE;
                end else begin
                    // Probe too large: this bit cannot be part of the target.
                    if (bus.gt) begin
                        probe_next[idx] = 1'b0;
                    end
                    if (idx != '0) begin
                        probe_next[idx - IW'(1)] = 1'b1;
                        idx_next                 = idx - IW'(1);
                    end else begin
                        state_next = VERIFY;
                    end
                end
            end
            VERIFY: begin
                found_next  = bus.eq;
                result_next = probe;
                if (!flags_ok) begin
                    err_next = 1'b1;
                end
                state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.probe  = probe;
    assign bus.result = result;
    assign bus.found  = found;
    assign bus.err    = err;
    assign bus.busy   = (state == SEARCH) || (state == VERIFY);
    assign bus.done   = (state == DONE);

endmodule

// File: tb/tb_sar_search.sv
// tb/tb_sar_search.sv - self-checking bench for sar_search with a behavioural comparator
module tb_sar_search;
    import sar_search_pkg::*;

    localparam int N = SAR_N_DEFAULT;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sar_search_if #(.N(N)) bus ();

    sar_search #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [N-1:0] target;
    logic         force_bad;

    assign bus.lt = force_bad | (bus.probe < target);
    assign bus.gt = force_bad | (bus.probe > target);
    assign bus.eq = !force_bad && (bus.probe == target);

    typedef struct {
        logic [N-1:0] res;
        logic         fnd;
        logic         er;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    logic [N-1:0] probe_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Start-to-done latency, counting the start-sampling cycle as cycle 1.
    function automatic int exp_lat(input logic [N-1:0] t);
`ifdef SAR_EARLY_EXIT_EN
        int tz;
        if (t == '0) return N + 2;
        tz = 0;
        while (t[tz] == 1'b0) tz++;
        return N - tz + 1;
`else
        return N + 2;
`endif
    endfunction

    // change_at: target becomes t2 after that sampling edge; force_at: flags forced bad
    // on that sampling edge; restart_at: extra start pulse after that edge (-1 = none).
    task automatic run(input string tag, input logic [N-1:0] t1, input logic [N-1:0] t2,
                       input int change_at, input int force_at, input int restart_at,
                       input logic [N-1:0] e_res, input logic e_fnd, input logic e_err,
                       input int e_lat);
        exp_t e;
        int   k;
        bit   seen;
        @(negedge clk);
        target    = t1;
        force_bad = 1'b0;
        sb.push_back('{res: e_res, fnd: e_fnd, er: e_err, lat: e_lat});
        bus.start = 1'b1;
        @(posedge clk);
        k    = 0;
        seen = 0;
        while (!seen && k < 40) begin
            @(negedge clk);
            bus.start = (k == restart_at);
            if (bus.done) begin
                seen = 1;
                e = sb.pop_front();
                check({tag, "_result"}, 32'(bus.result), 32'(e.res));
                check({tag, "_found"}, 32'(bus.found), 32'(e.fnd));
                check({tag, "_err"}, 32'(bus.err), 32'(e.er));
                check({tag, "_latency"}, 32'(k + 1), 32'(e.lat));
                check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
            end else begin
                if (k < N && probe_q.size() > 0) begin
                    check({tag, "_probe"}, 32'(bus.probe), 32'(probe_q.pop_front()));
                end
                if (k == change_at) target = t2;
                force_bad = (k + 1 == force_at);
                @(posedge clk);
                k++;
            end
        end
        force_bad = 1'b0;
        bus.start = 1'b0;
        if (!seen) begin
            check({tag, "_done_timeout"}, 32'd0, 32'd1);
            void'(sb.pop_front());
        end
        probe_q.delete();
        // Result and flags persist in IDLE and nothing restarts on its own.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
        end
        if (seen) begin
            check({tag, "_result_held"}, 32'(bus.result), 32'(e_res));
        end
    endtask

    initial begin
        logic [N-1:0] t;
        int           dones;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        target    = '0;
        force_bad = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_probe", 32'(bus.probe), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_found_err", 32'({bus.found, bus.err}), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        rst_n = 1'b1;

        probe_q = '{8'd128, 8'd64, 8'd32, 8'd48, 8'd40, 8'd44, 8'd42, 8'd43};
        run("t42", 8'd42, 8'd42, -1, -1, -1, 8'd42, 1'b1, 1'b0, exp_lat(8'd42));
        run("t0", 8'd0, 8'd0, -1, -1, -1, 8'd0, 1'b1, 1'b0, exp_lat(8'd0));
        run("t255", 8'd255, 8'd255, -1, -1, -1, 8'd255, 1'b1, 1'b0, exp_lat(8'd255));
        run("t128", 8'd128, 8'd128, -1, -1, -1, 8'd128, 1'b1, 1'b0, exp_lat(8'd128));
        run("t200", 8'd200, 8'd200, -1, -1, -1, 8'd200, 1'b1, 1'b0, exp_lat(8'd200));
`ifdef SAR_EARLY_EXIT_EN
        check("early_lat_128", 32'(exp_lat(8'd128)), 32'd2);
        check("early_lat_200", 32'(exp_lat(8'd200)), 32'd6);
`endif
        // Flags forced non-one-hot on the third search sample (probe 32).
        run("abort", 8'd42, 8'd42, -1, 3, -1, 8'd32, 1'b0, 1'b1, 4);
        // Target moves 150 -> 128 after four search samples.
        run("moved", 8'd150, 8'd128, 4, -1, -1, 8'd144, 1'b0, 1'b0, 10);
        // Extra start during SEARCH must not restart or queue a search.
        run("restart", 8'd77, 8'd77, -1, -1, 3, 8'd77, 1'b1, 1'b0, exp_lat(8'd77));

        for (int i = 0; i < 4; i++) begin
            t = N'($urandom_range(1, 254));
            run("rand", t, t, -1, -1, -1, t, 1'b1, 1'b0, exp_lat(t));
        end

        // Asynchronous reset in the middle of a search.
        @(negedge clk);
        target    = 8'd99;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_probe", 32'(bus.probe), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_result", 32'(bus.result), 32'd0);
        check("arst_flags", 32'({bus.done, bus.found, bus.err}), 32'd0);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        check("arst_start_ignored", 32'(bus.busy), 32'd0);
        bus.start = 1'b0;
        rst_n     = 1'b1;
        dones     = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("arst_no_done", 32'(dones), 32'd0);
        run("after_rst", 8'd99, 8'd99, -1, -1, -1, 8'd99, 1'b1, 1'b0, exp_lat(8'd99));

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
